// File: rtl/calc_alu_mc_if.sv
// rtl/calc_alu_mc_if.sv - request/result bundle between opcode decode and the calculator ALU
interface calc_alu_mc_if #(
  parameter int OPCODE_LENGTH = 5,
  parameter int NUM_LENGTH    = 9,
  parameter int RESULT_WIDTH  = 32
);
  logic                            start;
  logic [OPCODE_LENGTH-1:0]        Opcode;
  logic signed [NUM_LENGTH-1:0]    numA;
  logic signed [NUM_LENGTH-1:0]    numB;
  logic                            busy;
  logic                            done;
  logic signed [RESULT_WIDTH-1:0]  numC;
  logic signed [RESULT_WIDTH-1:0]  numMEM;
  logic                            err;
  logic                            ovf;

  modport master (
    output start, Opcode, numA, numB,
    input  busy, done, numC, numMEM, err, ovf
  );

  modport slave (
    input  start, Opcode, numA, numB,
    output busy, done, numC, numMEM, err, ovf
  );
endinterface

// File: rtl/calc_alu_mc.sv
// rtl/calc_alu_mc.sv - multi-cycle signed calculator ALU with iterative div/mod/sqrt and memory register
module calc_alu_mc #(
  parameter int OPCODE_LENGTH = 5,
  parameter int NUM_LENGTH    = 9,
  parameter int RESULT_WIDTH  = 32
) (
  input  logic         clk,
  input  logic         rst,
  calc_alu_mc_if.slave bus
);
  localparam int S    = (NUM_LENGTH + 1) / 2;
  localparam int SQ_W = 2 * S;
  localparam int SR_W = S + 3;
  localparam int CW   = $clog2(NUM_LENGTH + 1);

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV = 5'b00011, OP_SQR = 5'b00100, OP_CUBE = 5'b00101;
  localparam logic [4:0] OP_SQRT = 5'b00110, OP_MOD = 5'b01011, OP_PI  = 5'b01111;
  localparam logic [4:0] OP_MADD = 5'b10001, OP_MSUB = 5'b10010;
  localparam logic [4:0] OP_RCL = 5'b10100, OP_CLR = 5'b11000;

  if (RESULT_WIDTH < 3 * NUM_LENGTH) begin : g_width_check
    $error("RESULT_WIDTH must be at least 3*NUM_LENGTH");
  end
  if (OPCODE_LENGTH != 5) begin : g_opcode_check
    $error("opcode encoding is defined for OPCODE_LENGTH == 5 only");
  end

  typedef enum logic [1:0] {IDLE, DIV, SQRT, FIX} state_t;
  state_t state_q, state_d;

  logic signed [RESULT_WIDTH-1:0] a_ext, b_ext, mem_q, res_q;
  logic signed [RESULT_WIDTH-1:0] sc_res, mem_d, mem_sum, mem_dif, fix_res;
  logic                           sc_err, sc_ovf, done_q, err_q, ovf_q;
  logic                           is_div, a_neg, b_zero, go_div, go_sqrt, sc_fire;
  logic [NUM_LENGTH-1:0]          mag_a, mag_b;
  logic [CW-1:0]                  cnt_q;
  logic                           is_sqrt_q, is_mod_q, neg_a_q, neg_q_q;

  // Restoring divider: quo_q shifts the dividend out while the quotient bits shift in.
  logic [NUM_LENGTH-1:0]          quo_q, rem_q, dvs_q, quo_d, rem_d;
  logic [NUM_LENGTH:0]            shifted, trial;

  // Non-restoring square root: srem_q is a signed partial remainder.
  logic [SQ_W-1:0]                rad_q;
  logic [SR_W-1:0]                srem_q, srem_sh, srem_d;
  logic [S-1:0]                   root_q, root_d;

  assign a_ext   = {{(RESULT_WIDTH-NUM_LENGTH){bus.numA[NUM_LENGTH-1]}}, bus.numA};
  assign b_ext   = {{(RESULT_WIDTH-NUM_LENGTH){bus.numB[NUM_LENGTH-1]}}, bus.numB};
  assign a_neg   = bus.numA[NUM_LENGTH-1];
  assign b_zero  = (bus.numB == '0);
  assign is_div  = (bus.Opcode == OP_DIV) || (bus.Opcode == OP_MOD);
  assign mag_a   = a_neg ? (~bus.numA + 1'b1) : bus.numA;
  assign mag_b   = bus.numB[NUM_LENGTH-1] ? (~bus.numB + 1'b1) : bus.numB;
  assign mem_sum = mem_q + a_ext;
  assign mem_dif = mem_q - a_ext;

  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    sc_ovf = 1'b0;
    mem_d  = mem_q;
    case (bus.Opcode)
      OP_ADD:  sc_res = a_ext + b_ext;
      OP_SUB:  sc_res = a_ext - b_ext;
      OP_MUL:  sc_res = a_ext * b_ext;
      OP_SQR:  sc_res = a_ext * a_ext;
      OP_CUBE: sc_res = a_ext * a_ext * a_ext;
      OP_PI:   sc_res = RESULT_WIDTH'(3);
      OP_DIV, OP_MOD: sc_err = b_zero;
      OP_SQRT: sc_err = a_neg;
      OP_MADD: begin
        mem_d  = mem_sum;
        sc_res = mem_sum;
        sc_ovf = (mem_q[RESULT_WIDTH-1] == a_ext[RESULT_WIDTH-1]) &&
                 (mem_sum[RESULT_WIDTH-1] != mem_q[RESULT_WIDTH-1]);
      end
      OP_MSUB: begin
        mem_d  = mem_dif;
        sc_res = mem_dif;
        sc_ovf = (mem_q[RESULT_WIDTH-1] != a_ext[RESULT_WIDTH-1]) &&
                 (mem_dif[RESULT_WIDTH-1] != mem_q[RESULT_WIDTH-1]);
      end
      OP_RCL:  sc_res = mem_q;
      OP_CLR:  mem_d = '0;
      default: sc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    go_div  = 1'b0;
    go_sqrt = 1'b0;
    sc_fire = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        if (is_div && !b_zero) begin
          state_d = DIV;
          go_div  = 1'b1;
        end else if ((bus.Opcode == OP_SQRT) && !a_neg) begin
          state_d = SQRT;
          go_sqrt = 1'b1;
        end else begin
          sc_fire = 1'b1;
        end
      end
      DIV:  if (cnt_q == CW'(NUM_LENGTH - 1)) state_d = FIX;
      SQRT: if (cnt_q == CW'(S - 1)) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign shifted = {rem_q, quo_q[NUM_LENGTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign quo_d   = {quo_q[NUM_LENGTH-2:0], ~trial[NUM_LENGTH]};
  assign rem_d   = trial[NUM_LENGTH] ? shifted[NUM_LENGTH-1:0] : trial[NUM_LENGTH-1:0];

  assign srem_sh = (srem_q << 2) | SR_W'(rad_q[SQ_W-1 -: 2]);
  assign srem_d  = srem_q[SR_W-1] ? (srem_sh + SR_W'({root_q, 2'b11}))
                                  : (srem_sh - SR_W'({root_q, 2'b01}));
  assign root_d  = {root_q[S-2:0], ~srem_d[SR_W-1]};

  always_comb begin
    fix_res = RESULT_WIDTH'(root_q);
    if (!is_sqrt_q) begin
      if (is_mod_q) fix_res = neg_a_q ? -RESULT_WIDTH'(rem_q) : RESULT_WIDTH'(rem_q);
      else          fix_res = neg_q_q ? -RESULT_WIDTH'(quo_q) : RESULT_WIDTH'(quo_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;   cnt_q   <= '0;    res_q    <= '0;   mem_q   <= '0;
      done_q  <= 1'b0;   err_q   <= 1'b0;  ovf_q    <= 1'b0;
      is_sqrt_q <= 1'b0; is_mod_q <= 1'b0; neg_a_q  <= 1'b0; neg_q_q <= 1'b0;
      quo_q   <= '0;     rem_q   <= '0;    dvs_q    <= '0;
      rad_q   <= '0;     srem_q  <= '0;    root_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (sc_fire) begin
        res_q  <= sc_res;
        err_q  <= sc_err;
        ovf_q  <= sc_ovf;
        mem_q  <= mem_d;
        done_q <= 1'b1;
      end
      if (go_div) begin
        cnt_q     <= '0;
        is_sqrt_q <= 1'b0;
        is_mod_q  <= (bus.Opcode == OP_MOD);
        neg_a_q   <= a_neg;
        neg_q_q   <= a_neg ^ bus.numB[NUM_LENGTH-1];
        quo_q     <= mag_a;
        rem_q     <= '0;
        dvs_q     <= mag_b;
      end
      if (go_sqrt) begin
        cnt_q     <= '0;
        is_sqrt_q <= 1'b1;
        rad_q     <= SQ_W'(mag_a);
        srem_q    <= '0;
        root_q    <= '0;
      end
      if (state_q == DIV) begin
        cnt_q <= cnt_q + 1'b1;
        quo_q <= quo_d;
        rem_q <= rem_d;
      end
      if (state_q == SQRT) begin
        cnt_q  <= cnt_q + 1'b1;
        rad_q  <= rad_q << 2;
        srem_q <= srem_d;
        root_q <= root_d;
      end
      if (state_q == FIX) begin
        res_q  <= fix_res;
        err_q  <= 1'b0;
        ovf_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.numC   = res_q;
  assign bus.numMEM = mem_q;
  assign bus.err    = err_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_calc_alu_mc.sv
// tb/tb_calc_alu_mc.sv - directed self-checking bench for calc_alu_mc
module tb_calc_alu_mc;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, MUL = 5'b00010, DIV = 5'b00011;
  localparam logic [4:0] SQR = 5'b00100, CUBE = 5'b00101, SQRT = 5'b00110, MOD = 5'b01011;
  localparam logic [4:0] PI = 5'b01111, MADD = 5'b10001, MSUB = 5'b10010;
  localparam logic [4:0] RCL = 5'b10100, CLR = 5'b11000, BAD = 5'b00111;

  always #5 clk = ~clk;

  calc_alu_mc_if #(.OPCODE_LENGTH(5), .NUM_LENGTH(9), .RESULT_WIDTH(32)) if0 ();
  calc_alu_mc_if #(.OPCODE_LENGTH(5), .NUM_LENGTH(4), .RESULT_WIDTH(12)) if1 ();

  calc_alu_mc #(.OPCODE_LENGTH(5), .NUM_LENGTH(9), .RESULT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .bus(if0)
  );
  calc_alu_mc #(.OPCODE_LENGTH(5), .NUM_LENGTH(4), .RESULT_WIDTH(12)) u_small (
    .clk(clk), .rst(rst), .bus(if1)
  );

  // Issue one op on the default instance; lat = edges after the sampling edge until done registers.
  task automatic op0(input logic [4:0] opc, input int a, input int b,
                     output int lat, output int bcnt, output bit seen);
    @(negedge clk);
    if0.start = 1'b1; if0.Opcode = opc; if0.numA = a[8:0]; if0.numB = b[8:0];
    @(posedge clk);
    #1;
    if0.start = 1'b0; if0.Opcode = BAD; if0.numA = 9'h0AA; if0.numB = 9'h000;
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if0.busy) bcnt++;
      if (if0.done) begin seen = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic op1(input logic [4:0] opc, input int a, input int b,
                     output int lat, output bit seen);
    @(negedge clk);
    if1.start = 1'b1; if1.Opcode = opc; if1.numA = a[3:0]; if1.numB = b[3:0];
    @(posedge clk);
    #1;
    if1.start = 1'b0; if1.Opcode = BAD; if1.numA = 4'h5; if1.numB = 4'h0;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if1.done) begin seen = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", if0.busy); end
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", if0.done); end
    checks++; if (if0.numC !== 32'sd0) begin errors++; $display("FAIL reset_numC got %0d exp 0", if0.numC); end
    checks++; if (if0.numMEM !== 32'sd0) begin errors++; $display("FAIL reset_numMEM got %0d exp 0", if0.numMEM); end
    checks++; if ({if0.err, if0.ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {if0.err, if0.ovf}); end
  endtask

  task automatic test_add;
    int lat, bc; bit seen;
    op0(ADD, -5, 7, lat, bc, seen);
    checks++; if (!seen || lat != 0) begin errors++; $display("FAIL add_latency got %0d seen %b exp 0", lat, seen); end
    checks++; if (bc != 0) begin errors++; $display("FAIL add_busy got %0d cycles exp 0", bc); end
    checks++; if (if0.numC !== 2) begin errors++; $display("FAIL add_numC got %0d exp 2", if0.numC); end
    checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL add_err got %b exp 0", if0.err); end
    op0(SUB, 3, -4, lat, bc, seen);
    checks++; if (if0.numC !== 7) begin errors++; $display("FAIL sub_numC got %0d exp 7", if0.numC); end
    op0(MUL, -12, 11, lat, bc, seen);
    checks++; if (if0.numC !== -132) begin errors++; $display("FAIL mul_numC got %0d exp -132", if0.numC); end
    op0(SQR, 255, 0, lat, bc, seen);
    checks++; if (if0.numC !== 65025) begin errors++; $display("FAIL square_numC got %0d exp 65025", if0.numC); end
    op0(PI, 17, -9, lat, bc, seen);
    checks++; if (if0.numC !== 3) begin errors++; $display("FAIL pi_numC got %0d exp 3", if0.numC); end
  endtask

  task automatic test_cube;
    int lat, bc; bit seen;
    op0(CUBE, -256, 0, lat, bc, seen);
    checks++; if (if0.numC !== -16777216) begin errors++; $display("FAIL cube_numC got %0d exp -16777216", if0.numC); end
    op0(CUBE, 7, 0, lat, bc, seen);
    checks++; if (if0.numC !== 343) begin errors++; $display("FAIL cube7_numC got %0d exp 343", if0.numC); end
  endtask

  task automatic test_divide;
    int lat, bc; bit seen;
    op0(DIV, -100, 7, lat, bc, seen);
    checks++; if (!seen || lat != 10) begin errors++; $display("FAIL div_latency got %0d seen %b exp 10", lat, seen); end
    checks++; if (bc != 10) begin errors++; $display("FAIL div_busy got %0d cycles exp 10", bc); end
    checks++; if (if0.numC !== -14) begin errors++; $display("FAIL div_numC got %0d exp -14", if0.numC); end
    op0(MOD, -100, 7, lat, bc, seen);
    checks++; if (if0.numC !== -2) begin errors++; $display("FAIL mod_numC got %0d exp -2", if0.numC); end
    op0(MOD, 100, -7, lat, bc, seen);
    checks++; if (if0.numC !== 2) begin errors++; $display("FAIL mod_posA_numC got %0d exp 2", if0.numC); end
    op0(DIV, -256, -1, lat, bc, seen);
    checks++; if (if0.numC !== 256) begin errors++; $display("FAIL div_min_numC got %0d exp 256", if0.numC); end
    checks++; if ({if0.err, if0.ovf} !== 2'b00) begin errors++; $display("FAIL div_min_flags got %b exp 00", {if0.err, if0.ovf}); end
  endtask

  task automatic test_div_zero;
    int lat, bc; bit seen;
    op0(DIV, 5, 0, lat, bc, seen);
    checks++; if (!seen || lat != 0 || bc != 0) begin errors++; $display("FAIL divzero_timing got lat %0d busy %0d exp 0 0", lat, bc); end
    checks++; if (if0.numC !== 0 || if0.err !== 1'b1) begin errors++; $display("FAIL divzero_result got %0d err %b exp 0 err 1", if0.numC, if0.err); end
    op0(ADD, 1, 1, lat, bc, seen);
    checks++; if (if0.numC !== 2 || if0.err !== 1'b0) begin errors++; $display("FAIL after_divzero got %0d err %b exp 2 err 0", if0.numC, if0.err); end
    op0(BAD, 9, 9, lat, bc, seen);
    checks++; if (if0.numC !== 0 || if0.err !== 1'b1) begin errors++; $display("FAIL badop got %0d err %b exp 0 err 1", if0.numC, if0.err); end
  endtask

  task automatic test_sqrt;
    int lat, bc; bit seen;
    op0(SQRT, 255, 0, lat, bc, seen);
    checks++; if (!seen || lat != 6) begin errors++; $display("FAIL sqrt_latency got %0d seen %b exp 6", lat, seen); end
    checks++; if (bc != 6) begin errors++; $display("FAIL sqrt_busy got %0d cycles exp 6", bc); end
    checks++; if (if0.numC !== 15 || if0.err !== 1'b0) begin errors++; $display("FAIL sqrt255 got %0d err %b exp 15 err 0", if0.numC, if0.err); end
    op0(SQRT, 100, 0, lat, bc, seen);
    checks++; if (if0.numC !== 10) begin errors++; $display("FAIL sqrt100 got %0d exp 10", if0.numC); end
    op0(SQRT, -4, 0, lat, bc, seen);
    checks++; if (!seen || lat != 0) begin errors++; $display("FAIL sqrtneg_latency got %0d exp 0", lat); end
    checks++; if (if0.numC !== 0 || if0.err !== 1'b1) begin errors++; $display("FAIL sqrtneg got %0d err %b exp 0 err 1", if0.numC, if0.err); end
  endtask

  task automatic test_back_to_back;
    int dn; logic signed [31:0] res;
    dn = 0; res = '0;
    @(negedge clk);
    if0.start = 1'b1; if0.Opcode = DIV; if0.numA = 9'sd100; if0.numB = 9'sd3;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (if0.done) begin dn++; res = if0.numC; end
      if (i == 3) begin if0.start = 1'b1; if0.Opcode = ADD; if0.numA = 9'sd1; if0.numB = 9'sd1; end
      else if0.start = 1'b0;
    end
    checks++; if (dn != 1) begin errors++; $display("FAIL busy_start_dones got %0d exp 1", dn); end
    checks++; if (res !== 33) begin errors++; $display("FAIL busy_start_result got %0d exp 33", res); end
    checks++; if (if0.numC !== 33 || if0.err !== 1'b0) begin errors++; $display("FAIL busy_start_final got %0d err %b exp 33 err 0", if0.numC, if0.err); end
  endtask

  task automatic test_memory;
    int lat, bc; bit seen;
    op0(CLR, 0, 0, lat, bc, seen);
    checks++; if (if0.numMEM !== 0 || if0.numC !== 0) begin errors++; $display("FAIL mem_clear got %0d %0d exp 0 0", if0.numMEM, if0.numC); end
    for (int i = 0; i < 3; i++) op0(MADD, 200, 0, lat, bc, seen);
    checks++; if (if0.numMEM !== 600 || if0.numC !== 600) begin errors++; $display("FAIL mem_add got %0d %0d exp 600", if0.numMEM, if0.numC); end
    op0(MSUB, -50, 0, lat, bc, seen);
    checks++; if (if0.numMEM !== 650 || if0.ovf !== 1'b0) begin errors++; $display("FAIL mem_sub got %0d ovf %b exp 650 ovf 0", if0.numMEM, if0.ovf); end
    op0(ADD, 4, 4, lat, bc, seen);
    checks++; if (if0.numMEM !== 650) begin errors++; $display("FAIL mem_hold got %0d exp 650", if0.numMEM); end
    op0(RCL, 0, 0, lat, bc, seen);
    checks++; if (if0.numC !== 650) begin errors++; $display("FAIL mem_recall got %0d exp 650", if0.numC); end
  endtask

  task automatic test_mem_overflow;
    int lat; bit seen;
    op1(CLR, 0, 0, lat, seen);
    for (int i = 0; i < 292; i++) op1(MADD, 7, 0, lat, seen);
    op1(MADD, 3, 0, lat, seen);
    checks++; if (if1.numMEM !== 12'sd2047 || if1.ovf !== 1'b0) begin errors++; $display("FAIL mem_max got %0d ovf %b exp 2047 ovf 0", if1.numMEM, if1.ovf); end
    op1(MADD, 1, 0, lat, seen);
    checks++; if (if1.numMEM !== -12'sd2048 || if1.ovf !== 1'b1) begin errors++; $display("FAIL mem_add_ovf got %0d ovf %b exp -2048 ovf 1", if1.numMEM, if1.ovf); end
    checks++; if (if1.numC !== -12'sd2048) begin errors++; $display("FAIL mem_add_ovf_numC got %0d exp -2048", if1.numC); end
    op1(MSUB, 1, 0, lat, seen);
    checks++; if (if1.numMEM !== 12'sd2047 || if1.ovf !== 1'b1) begin errors++; $display("FAIL mem_sub_ovf got %0d ovf %b exp 2047 ovf 1", if1.numMEM, if1.ovf); end
    op1(RCL, 0, 0, lat, seen);
    checks++; if (if1.ovf !== 1'b0 || if1.numC !== 12'sd2047) begin errors++; $display("FAIL mem_ovf_clear got %0d ovf %b exp 2047 ovf 0", if1.numC, if1.ovf); end
    op1(DIV, -8, -1, lat, seen);
    checks++; if (!seen || lat != 5 || if1.numC !== 12'sd8) begin errors++; $display("FAIL small_div got %0d lat %0d exp 8 lat 5", if1.numC, lat); end
  endtask

  task automatic test_reset_mid_op;
    int dn;
    dn = 0;
    @(negedge clk);
    if0.start = 1'b1; if0.Opcode = DIV; if0.numA = 9'sd100; if0.numB = 9'sd3;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL midop_busy_before got %b exp 1", if0.busy); end
    rst = 1'b1;
    #1;
    checks++; if (if0.busy !== 1'b0 || if0.done !== 1'b0) begin errors++; $display("FAIL midop_busy_after got %b done %b exp 0 0", if0.busy, if0.done); end
    checks++; if (if0.numMEM !== 0 || if0.numC !== 0) begin errors++; $display("FAIL midop_regs got %0d %0d exp 0 0", if0.numMEM, if0.numC); end
    @(negedge clk);
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (if0.done) dn++;
    end
    checks++; if (dn != 0 || if0.busy !== 1'b0) begin errors++; $display("FAIL midop_no_done got %0d dones busy %b exp 0 0", dn, if0.busy); end
  endtask

  initial begin
    rst = 1'b1;
    if0.start = 1'b0; if0.Opcode = '0; if0.numA = '0; if0.numB = '0;
    if1.start = 1'b0; if1.Opcode = '0; if1.numA = '0; if1.numB = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_add;
    test_cube;
    test_divide;
    test_div_zero;
    test_sqrt;
    test_back_to_back;
    test_memory;
    test_mem_overflow;
    test_reset_mid_op;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
